// File: rtl/ws2812b_rx_if.sv
// ws2812b_rx_if: serial line plus decoded pixel/status bundle of the WS2812B receiver.
// The slave side is the receiver; the master side drives din and observes the results.
interface ws2812b_rx_if;
    logic       din;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    logic       pixel_valid;
    logic       frame_end;
    logic       bit_error;
    logic       busy;
    logic       dout;

    modport slave (
        input  din,
        output g, r, b, pixel_valid, frame_end, bit_error, busy, dout
    );

    modport master (
        output din,
        input  g, r, b, pixel_valid, frame_end, bit_error, busy, dout
    );
endinterface

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B single-wire decoder; latches the first 24 bits of a frame as G,R,B.
// Define WS2812B_RX_FORWARD_EN to regenerate the bits after the first pixel on dout.
module ws2812b_rx #(
    parameter int T_THRESH = 32,
    parameter int T_MIN_H  = 8,
    parameter int T_MAX_H  = 60,
    parameter int T_RESET  = 2500
) (
    input  logic        clock,
    input  logic        reset,
    ws2812b_rx_if.slave rx
);

    localparam logic [11:0] THRESH_W = 12'(T_THRESH);
    localparam logic [11:0] MIN_H_W  = 12'(T_MIN_H);
    localparam logic [11:0] MAX_H_W  = 12'(T_MAX_H);
    localparam logic [11:0] RESET_W  = 12'(T_RESET);
    localparam logic [4:0]  PIXEL_BITS = 5'd24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DISCARD
    } state_t;

    state_t      state;
    logic        din_meta;
    logic        ds;
    logic        ds_q;
    logic        ds_rise;
    logic [11:0] hcnt;
    logic [11:0] lcnt;
    logic [4:0]  bit_cnt;
    logic [23:0] shift_reg;
    logic [23:0] shift_next;
    logic        bit_val;
    logic        short_frame;
    logic [7:0]  g_q;
    logic [7:0]  r_q;
    logic [7:0]  b_q;
    logic        pixel_valid_q;
    logic        frame_end_q;
    logic        bit_error_q;
    logic        busy_q;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // Equal delay on both edges keeps measured widths identical to din widths.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_meta <= 1'b0;
            ds       <= 1'b0;
            ds_q     <= 1'b0;
        end else begin
            din_meta <= rx.din;
            ds       <= din_meta;
            ds_q     <= ds;
        end
    end

    assign ds_rise     = ds & ~ds_q;
    assign bit_val     = (hcnt >= THRESH_W);
    assign shift_next  = {shift_reg[22:0], bit_val};
    assign short_frame = (bit_cnt != 5'd0) && (bit_cnt < PIXEL_BITS);

    // hcnt/lcnt hold the number of high/low cycles already seen in the current level.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            hcnt          <= 12'd0;
            lcnt          <= 12'd0;
            bit_cnt       <= 5'd0;
            shift_reg     <= 24'd0;
            g_q           <= 8'd0;
            r_q           <= 8'd0;
            b_q           <= 8'd0;
            pixel_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            bit_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            bit_error_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ds_rise) begin
                        state  <= S_HIGH;
                        busy_q <= 1'b1;
                        hcnt   <= 12'd1;
                    end
                end

                S_HIGH: begin
                    if (ds) begin
                        if (hcnt >= MAX_H_W) begin
                            bit_error_q <= 1'b1;
                            state       <= S_DISCARD;
                            lcnt        <= 12'd0;
                        end else begin
                            hcnt <= sat_inc(hcnt);
                        end
                    end else if (hcnt < MIN_H_W) begin
                        bit_error_q <= 1'b1;
                        state       <= S_DISCARD;
                        lcnt        <= 12'd1;
                    end else begin
                        // Bits past the first pixel are counted as forwarded only.
                        if (bit_cnt < PIXEL_BITS) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 5'd1;
                            if (bit_cnt == PIXEL_BITS - 5'd1) begin
                                g_q           <= shift_next[23:16];
                                r_q           <= shift_next[15:8];
                                b_q           <= shift_next[7:0];
                                pixel_valid_q <= 1'b1;
                            end
                        end
                        state <= S_LOW;
                        lcnt  <= 12'd1;
                    end
                end

                S_LOW: begin
                    // The latch gap takes priority over a rise arriving on the same cycle.
                    if (lcnt >= RESET_W) begin
                        frame_end_q <= 1'b1;
                        bit_error_q <= short_frame;
                        bit_cnt     <= 5'd0;
                        busy_q      <= 1'b0;
                        lcnt        <= 12'd0;
                        state       <= S_IDLE;
                    end else if (ds_rise) begin
                        state <= S_HIGH;
                        hcnt  <= 12'd1;
                    end else begin
                        lcnt <= sat_inc(lcnt);
                    end
                end

                S_DISCARD: begin
                    if (ds) begin
                        lcnt <= 12'd0;
                    end else if (lcnt >= RESET_W) begin
                        frame_end_q <= 1'b1;
                        bit_error_q <= short_frame;
                        bit_cnt     <= 5'd0;
                        busy_q      <= 1'b0;
                        lcnt        <= 12'd0;
                        state       <= S_IDLE;
                    end else begin
                        lcnt <= sat_inc(lcnt);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef WS2812B_RX_FORWARD_EN
    logic dout_q;

    // Regenerated stream follows ds only once the pixel is full and the frame is still live.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= ds && (bit_cnt == PIXEL_BITS) &&
                      ((state == S_HIGH) || ((state == S_LOW) && (lcnt < RESET_W)));
        end
    end

    assign rx.dout = dout_q;
`else
    assign rx.dout = 1'b0;
`endif

    assign rx.g           = g_q;
    assign rx.r           = r_q;
    assign rx.b           = b_q;
    assign rx.pixel_valid = pixel_valid_q;
    assign rx.frame_end   = frame_end_q;
    assign rx.bit_error   = bit_error_q;
    assign rx.busy        = busy_q;

endmodule
